// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes six active-low 7-segment codes onto one
// shared segment bus with one-hot active-low digit enables. Each frame works
// from a snapshot of the inputs taken at the frame wrap. Selected digits blink,
// and all digits blink while isCorrect is high.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD        = 8,
  parameter int unsigned BLINK_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Display1,
  input  logic [6:0] Display2,
  input  logic [6:0] Display3,
  input  logic [6:0] Display4,
  input  logic [6:0] Display5,
  input  logic [6:0] Display6,
  input  logic [5:0] blink_mask,
  input  logic       isCorrect,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_tick
);

  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W:0]   GUARD_V = (DIV_W + 1)'(GUARD);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'd5;
  localparam logic [6:0]       SEG_OFF = 7'h7F;
  localparam logic [5:0]       AN_OFF  = 6'h3F;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [6:0]       snap_q [6];
  logic [6:0]       snap_d [6];
  logic [5:0]       snap_mask_q, snap_mask_d;
  logic             snap_all_q, snap_all_d;
  logic [6:0]       seg_q, seg_d;
  logic [5:0]       an_q, an_d;
  logic             frame_tick_q, frame_tick_d;

  logic [6:0] disp [6];
  logic       div_wrap;
  logic       frame_wrap;
  logic       blank;

  // Gather the display inputs into an indexable array (digit 0 = Display1).
  always_comb begin
    disp[0] = Display1;
    disp[1] = Display2;
    disp[2] = Display3;
    disp[3] = Display4;
    disp[4] = Display5;
    disp[5] = Display6;
  end

  // Next-state logic for the scan counters, blink timer and frame snapshot.
  always_comb begin
    div_wrap      = (div_cnt_q == DIV_MAX);
    frame_wrap    = div_wrap && (digit_q == LAST_DIGIT);
    div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
    digit_d       = digit_q;
    frm_cnt_d     = frm_cnt_q;
    blink_phase_d = blink_phase_q;
    snap_d        = snap_q;
    snap_mask_d   = snap_mask_q;
    snap_all_d    = snap_all_q;
    if (div_wrap) begin
      digit_d = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
    end
    if (frame_wrap) begin
      snap_d      = disp;
      snap_mask_d = blink_mask;
      snap_all_d  = isCorrect;
      if (frm_cnt_q == FRM_MAX) begin
        frm_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frm_cnt_d = frm_cnt_q + 1'b1;
      end
    end
  end

  // Moore outputs derived from next-state values so they line up with the state they show.
  always_comb begin
    seg_d        = SEG_OFF;
    an_d         = AN_OFF;
    frame_tick_d = frame_wrap;
    blank        = blink_phase_d & (snap_mask_d[digit_d] | snap_all_d);
    if ({1'b0, div_cnt_d} >= GUARD_V) begin
      an_d = ~(6'b000001 << digit_d);
      if (!blank) begin
        seg_d = snap_d[digit_d];
      end
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      digit_q       <= '0;
      frm_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
        snap_q[i] <= SEG_OFF;
      end
      snap_mask_q   <= '0;
      snap_all_q    <= 1'b0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_q       <= digit_d;
      frm_cnt_q     <= frm_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      snap_mask_q   <= snap_mask_d;
      snap_all_q    <= snap_all_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
